// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM encoding and default widths.
// Intended to be reused by the buffered receiver as well.
package uart_pkg;

    localparam int CNT_W_DEFAULT = 32;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Mode 3 is reserved and behaves like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with show-ahead read data and a 0..FIFO_DEPTH occupancy count.
// Push while full and pop while empty are ignored.
module uart_sync_fifo #(
    parameter  int DATA_W     = 9,
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LW         = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LW-1:0]     level_o
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              do_push;
    logic              do_pop;

    assign full_o     = (level_q == LW'(FIFO_DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // NOTE: storage has no reset; only pointers and level define validity, so the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: queues pushed words and sends LSB-first frames with
// runtime-selectable data width, parity and stop bits; frame settings are latched at pop.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter  int DATA_W     = 9,
    parameter  int FIFO_DEPTH = 16,
    parameter  int CNT_W      = CNT_W_DEFAULT,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  clk_div,
    input  logic [3:0]        cfg_bits,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    input  logic              tx_en,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam logic [3:0] BITS_MIN = 4'd5;
    localparam logic [3:0] BITS_MAX = 4'(DATA_W);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  div_last_q, div_last_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [3:0]        bits_last_q, bits_last_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_bit_q, par_bit_d;
    logic              par_en_q, par_en_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [DATA_W-1:0] masked_data;
    logic [3:0]        bits_eff;
    logic [CNT_W-1:0]  div_eff_last;
    logic              bit_last;
    logic              stop_last;

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (wr_valid),
        .push_data_i (wr_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rd_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // Frame settings as they will be latched at the next pop.
    assign bits_eff     = (cfg_bits < BITS_MIN || cfg_bits > BITS_MAX) ? BITS_MAX : cfg_bits;
    assign div_eff_last = (clk_div == '0) ? '0 : clk_div - CNT_W'(1);

    always_comb begin
        masked_data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (4'(i) < bits_eff) begin
                masked_data[i] = fifo_rd_data[i];
            end
        end
    end

    assign bit_last  = (cnt_q == div_last_q);
    assign stop_last = (bit_idx_q[0] == stop2_q);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_last_d  = div_last_q;
        bit_idx_d   = bit_idx_q;
        bits_last_d = bits_last_q;
        shift_d     = shift_q;
        par_bit_d   = par_bit_q;
        par_en_d    = par_en_q;
        stop2_d     = stop2_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_last ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_en && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    state_d     = ST_START;
                    cnt_d       = '0;
                    tx_d        = 1'b0;
                    shift_d     = masked_data;
                    par_bit_d   = (cfg_parity == PAR_ODD) ? ~^masked_data : ^masked_data;
                    par_en_d    = parity_enabled(cfg_parity);
                    stop2_d     = cfg_stop2;
                    div_last_d  = div_eff_last;
                    bits_last_d = bits_eff - 4'd1;
                end
            end
            ST_START: begin
                if (bit_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    if (bit_idx_q == bits_last_q) begin
                        bit_idx_d = '0;
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_last) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_last) begin
                    tx_d = 1'b1;
                    if (stop_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_idx_d = 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_last_q  <= '0;
            bit_idx_q   <= '0;
            bits_last_q <= '0;
            shift_q     <= '0;
            par_bit_q   <= 1'b0;
            par_en_q    <= 1'b0;
            stop2_q     <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_last_q  <= div_last_d;
            bit_idx_q   <= bit_idx_d;
            bits_last_q <= bits_last_d;
            shift_q     <= shift_d;
            par_bit_q   <= par_bit_d;
            par_en_q    <= par_en_d;
            stop2_q     <= stop2_d;
            tx_q        <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != ST_IDLE);
    assign tx_done  = (state_q == ST_STOP) && bit_last && stop_last;
    assign wr_ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: a frame-level waveform model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed bit patterns and lengths.
module tb_uart_tx_buffered;

    localparam int DATA_W     = 9;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 32;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic [CNT_W-1:0]  clk_div;
    logic [3:0]        cfg_bits;
    logic [1:0]        cfg_parity;
    logic              cfg_stop2;
    logic              tx_en;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              tx;
    logic              busy;
    logic              tx_done;
    logic [LVL_W-1:0]  fifo_level;

    int checks   = 0;
    int failures = 0;

    uart_tx_buffered #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_div    (clk_div),
        .cfg_bits   (cfg_bits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_en      (tx_en),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queued words plus the per-cycle line level of the frame in flight.
    logic [DATA_W-1:0] mq[$];
    bit                wave[$];

    task automatic build_wave(input logic [DATA_W-1:0] w);
        bit fb[$];
        int d;
        int b;
        bit p;
        d = (clk_div == 0) ? 1 : int'(clk_div);
        b = (cfg_bits < 5 || cfg_bits > DATA_W) ? DATA_W : int'(cfg_bits);
        p = 1'b0;
        fb.push_back(1'b0);
        for (int i = 0; i < b; i++) begin
            fb.push_back(w[i]);
            p ^= w[i];
        end
        if (cfg_parity == 2'd1) fb.push_back(p);
        if (cfg_parity == 2'd2) fb.push_back(~p);
        fb.push_back(1'b1);
        if (cfg_stop2) fb.push_back(1'b1);
        foreach (fb[k]) begin
            for (int r = 0; r < d; r++) wave.push_back(fb[k]);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            wave.delete();
        end else begin
            bit full_pre;
            bit start;
            full_pre = (mq.size() >= FIFO_DEPTH);
            start    = (wave.size() == 0) && tx_en && (mq.size() != 0);
            if (wave.size() != 0) void'(wave.pop_front());
            if (start) build_wave(mq.pop_front());
            if (wr_valid && !full_pre) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        logic exp_tx;
        exp_tx = (wave.size() != 0) ? wave[0] : 1'b1;
        check("cmp_tx", tx, exp_tx);
        check("cmp_busy", busy, (wave.size() != 0));
        check("cmp_done", tx_done, (wave.size() == 1));
        check("cmp_level", fifo_level, mq.size());
        check("cmp_ready", wr_ready, (mq.size() < FIFO_DEPTH));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input bit stop2);
        clk_div    = CNT_W'(div);
        cfg_bits   = 4'(bits);
        cfg_parity = 2'(par);
        cfg_stop2  = stop2;
    endtask

    // Push into an idle, empty, enabled transmitter and compare the line against a literal.
    task automatic send_check(input logic [DATA_W-1:0] w, input logic [15:0] lit,
                              input int nbits, input int div, input string name);
        push(w);
        tick();
        for (int c = 0; c < nbits * div; c++) begin
            if (c % div == div / 2) check(name, tx, lit[c / div]);
            if (c == 0) check("frame_busy", busy, 1'b1);
            if (c == nbits * div - 1) check("frame_done", tx_done, 1'b1);
            tick();
        end
        check("frame_end_busy", busy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (busy || fifo_level != 0); i++) tick();
        check("drain_timeout", (busy || fifo_level != 0), 1'b0);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 50 && !busy; i++) tick();
        check("busy_rise_timeout", busy, 1'b1);
    endtask

    initial begin
        int n1;
        int n2;
        int gap;
        rst_n    = 1'b0;
        tx_en    = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        set_cfg(4, 8, 0, 1'b0);
        repeat (3) tick();
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_level", fifo_level, 0);
        check("reset_ready", wr_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // 1) 8N1 at 4 clocks per bit.
        send_check(9'h0A5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, "t1_8n1_a5");

        // 2) 7E2 and 8O1 at 2 clocks per bit.
        set_cfg(2, 7, 1, 1'b1);
        send_check(9'h041, {5'b0, 1'b1, 1'b1, 1'b0, 7'h41, 1'b0}, 11, 2, "t2_7e2_41");
        set_cfg(2, 8, 2, 1'b0);
        send_check(9'h000, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 2, "t2_8o1_00");

        // 3) Fill a disabled transmitter past full, then release it.
        set_cfg(1, 8, 0, 1'b0);
        tx_en = 1'b0;
        push(9'h011); push(9'h022); push(9'h033); push(9'h044); push(9'h055);
        check("t3_level_full", fifo_level, 4);
        check("t3_ready_low", wr_ready, 1'b0);
        tx_en = 1'b1;
        wait_busy();
        for (int i = 0; i < 50 && busy; i++) tick();
        gap = 0;
        for (int i = 0; i < 50 && !busy; i++) begin
            gap++;
            tick();
        end
        check("t3_idle_gap", gap, 1);
        drain();

        // 4) Simultaneous push and pop at level 2, then a push into a full queue during a pop.
        tx_en = 1'b0;
        push(9'h101); push(9'h102);
        tx_en = 1'b1;
        push(9'h103);
        tx_en = 1'b0;
        check("t4_level_pushpop", fifo_level, 2);
        push(9'h104); push(9'h105);
        check("t4_level_full", fifo_level, 4);
        for (int i = 0; i < 50 && busy; i++) tick();
        tx_en = 1'b1;
        push(9'h1FF);
        check("t4_full_drop", fifo_level, 3);
        drain();

        // 5) Asynchronous reset in the middle of a data bit.
        set_cfg(4, 8, 0, 1'b0);
        tx_en = 1'b0;
        push(9'h0C3); push(9'h03C);
        tx_en = 1'b1;
        repeat (12) tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_done", tx_done, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_check(9'h05A, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 4, "t5_clean_5a");

        // 6) Divider of zero, then a divider change in the middle of a frame.
        set_cfg(0, 8, 0, 1'b0);
        send_check(9'h0A5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1, "t6_div0_a5");
        set_cfg(3, 8, 0, 1'b0);
        tx_en = 1'b0;
        push(9'h1AB); push(9'h1CD);
        tx_en = 1'b1;
        wait_busy();
        n1 = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            n1++;
            if (n1 == 5) begin
                clk_div  = 2;
                cfg_bits = 4'd15;
            end
            tick();
        end
        check("t6_len_div3", n1, 30);
        wait_busy();
        n2 = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            n2++;
            tick();
        end
        check("t6_len_div2_clamp9", n2, 22);
        drain();

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
